// File: rtl/ccu_snoop_data_forwarder.sv
// Snoop data forwarder: streams the first responder's CD line data as AXI R beats and drains every CD channel.
// Optional perf counters are built when CCU_SNOOP_FWD_PERF_EN is defined; otherwise perf outputs are tied to 0.
module ccu_snoop_data_forwarder #(
  parameter int unsigned LineWords  = 4,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned FifoDepth  = 2,
  localparam int unsigned WIdxW     = $clog2(LineWords),
  localparam int unsigned PortW     = $clog2(NoMstPorts)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [1:0]                       req_op_i,
  input  logic [IdWidth-1:0]               req_id_i,
  input  logic [WIdxW-1:0]                 req_word_i,
  input  logic [7:0]                       req_len_i,
  input  logic                             shared_i,
  input  logic                             dirty_i,
  input  logic [NoMstPorts-1:0]            data_avail_i,
  input  logic [PortW-1:0]                 first_resp_i,
  input  logic [NoMstPorts*DataWidth-1:0]  cd_data_i,
  input  logic [NoMstPorts-1:0]            cd_last_i,
  input  logic [NoMstPorts-1:0]            cd_valid_i,
  output logic [NoMstPorts-1:0]            cd_ready_o,
  output logic [DataWidth-1:0]             r_data_o,
  output logic [IdWidth-1:0]               r_id_o,
  output logic [3:0]                       r_resp_o,
  output logic                             r_last_o,
  output logic                             r_valid_o,
  input  logic                             r_ready_i,
  output logic                             busy_o,
  output logic [31:0]                      perf_beats_o,
  output logic [31:0]                      perf_stall_o
);

  localparam int unsigned SumW = ((WIdxW > 8) ? WIdxW : 8) + 1;
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam logic [1:0] OpInvAck  = 2'd1;
  localparam logic [1:0] OpForward = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_STREAM, S_DRAIN} state_e;

  state_e                  state_q;
  logic [IdWidth-1:0]      id_q;
  logic [WIdxW-1:0]        start_q;
  logic [WIdxW-1:0]        end_q;
  logic                    oob_q;
  logic                    shared_q;
  logic                    dirty_q;
  logic [NoMstPorts-1:0]   avail_q;
  logic [PortW-1:0]        first_q;
  logic [NoMstPorts-1:0]   last_seen_q;
  logic [WIdxW:0]          rx_word_q;
  logic [PtrW-1:0]         wr_ptr_q;
  logic [PtrW-1:0]         rd_ptr_q;
  logic [CntW-1:0]         cnt_q;

  logic [DataWidth-1:0]    fifo_data_q  [FifoDepth];
  logic [WIdxW:0]          fifo_idx_q   [FifoDepth];
  logic [FifoDepth-1:0]    fifo_early_q;

  logic [SumW-1:0]         sum_d;
  logic                    oob_d;
  logic [WIdxW-1:0]        end_d;
  logic [NoMstPorts-1:0]   avail_d;

  logic                    busy;
  logic                    stream;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [NoMstPorts-1:0]   cd_hs;
  logic [NoMstPorts-1:0]   seen_now;
  logic                    all_done;
  logic [DataWidth-1:0]    cd_data_arr [NoMstPorts];
  logic                    push;
  logic                    push_early;
  logic [DataWidth-1:0]    head_data;
  logic [WIdxW:0]          head_idx;
  logic                    head_early;
  logic                    head_in_range;
  logic                    head_is_last;
  logic                    head_err;
  logic                    present;
  logic                    discard;
  logic                    r_hs;
  logic                    pop;
  logic                    r_done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request decode: clamp the burst end to the line and flag an out-of-line burst.
  assign sum_d = SumW'(req_word_i) + SumW'(req_len_i);
  assign oob_d = sum_d > SumW'(LineWords - 1);
  assign end_d = oob_d ? WIdxW'(LineWords - 1) : sum_d[WIdxW-1:0];

  always_comb begin
    avail_d = data_avail_i;
    avail_d[first_resp_i] = 1'b1;
  end

  assign busy        = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign stream      = (state_q == S_STREAM);
  assign busy_o      = busy;
  assign req_ready_o = (state_q == S_IDLE);
  assign fifo_full   = (cnt_q == CntW'(FifoDepth));
  assign fifo_empty  = (cnt_q == '0);

  for (genvar gi = 0; gi < NoMstPorts; gi++) begin : g_port
    assign cd_data_arr[gi] = cd_data_i[gi*DataWidth +: DataWidth];
    assign cd_ready_o[gi]  = busy && avail_q[gi] && !last_seen_q[gi] &&
                             !((first_q == PortW'(gi)) && fifo_full);
  end

  assign cd_hs    = cd_valid_i & cd_ready_o;
  assign seen_now = last_seen_q | (cd_hs & cd_last_i);
  assign all_done = &(seen_now | ~avail_q);

  // Only the first responder's words enter the FIFO; other ports are simply drained.
  assign push       = stream && cd_hs[first_q];
  assign push_early = cd_last_i[first_q] && (rx_word_q < (WIdxW+1)'(LineWords - 1));

  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_early = fifo_early_q[rd_ptr_q];

  // A truncated line still owes the master a terminating beat, even before the start word.
  assign head_in_range = (head_idx <= {1'b0, end_q}) &&
                         ((head_idx >= {1'b0, start_q}) || head_early);
  assign head_is_last  = (head_idx == {1'b0, end_q}) || head_early;
  assign head_err      = oob_q || head_early;

  assign present = stream && !fifo_empty && head_in_range;
  assign discard = stream && !fifo_empty && !head_in_range;
  assign r_hs    = present && r_ready_i;
  assign pop     = discard || r_hs;
  assign r_done  = r_hs && head_is_last;

  always_comb begin
    r_valid_o = 1'b0;
    r_id_o    = id_q;
    r_data_o  = '0;
    r_resp_o  = '0;
    r_last_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        r_valid_o = req_valid_i && (req_op_i == OpInvAck);
        r_id_o    = req_id_i;
        r_last_o  = 1'b1;
      end
      S_ACK: begin
        r_valid_o = 1'b1;
        r_last_o  = 1'b1;
      end
      S_STREAM: begin
        r_valid_o = present;
        r_data_o  = present ? head_data : '0;
        r_resp_o  = present ? {shared_q, dirty_q, (head_err ? 2'b10 : 2'b00)} : 4'b0000;
        r_last_o  = present && head_is_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= cd_data_arr[first_q];
      fifo_idx_q[wr_ptr_q]   <= rx_word_q;
      fifo_early_q[wr_ptr_q] <= push_early;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      start_q     <= '0;
      end_q       <= '0;
      oob_q       <= 1'b0;
      shared_q    <= 1'b0;
      dirty_q     <= 1'b0;
      avail_q     <= '0;
      first_q     <= '0;
      last_seen_q <= '0;
      rx_word_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      last_seen_q <= busy ? seen_now : '0;
      // Words left behind the final beat are dropped; DRAIN only sinks CD traffic.
      if (!stream || r_done) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      end
      if (push) rx_word_q <= rx_word_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            if (req_op_i == OpForward) begin
              id_q      <= req_id_i;
              start_q   <= req_word_i;
              end_q     <= end_d;
              oob_q     <= oob_d;
              shared_q  <= shared_i;
              dirty_q   <= dirty_i;
              avail_q   <= avail_d;
              first_q   <= first_resp_i;
              rx_word_q <= '0;
              state_q   <= S_STREAM;
            end else if ((req_op_i == OpInvAck) && !r_ready_i) begin
              id_q    <= req_id_i;
              state_q <= S_ACK;
            end
          end
        end
        S_ACK:    if (r_ready_i) state_q <= S_IDLE;
        S_STREAM: if (r_done) state_q <= all_done ? S_IDLE : S_DRAIN;
        S_DRAIN:  if (all_done) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CCU_SNOOP_FWD_PERF_EN
  logic [31:0] perf_beats_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (r_valid_o && r_ready_i && (perf_beats_q != '1))  perf_beats_q <= perf_beats_q + 1'b1;
      if (r_valid_o && !r_ready_i && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_beats_o = perf_beats_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_beats_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ccu_snoop_data_forwarder.sv
// Randomized bench for ccu_snoop_data_forwarder: a line-level reference model predicts the R beat stream,
// drain completion, backpressure absorption and (if CCU_SNOOP_FWD_PERF_EN) the perf counters.
module tb_ccu_snoop_data_forwarder;

  localparam int LW = 4;
  localparam int DW = 64;
  localparam int NP = 4;
  localparam int IW = 6;
  localparam int FD = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = '0;
  logic [IW-1:0]     req_id = '0;
  logic [1:0]        req_word = '0;
  logic [7:0]        req_len = '0;
  logic              shared = 1'b0;
  logic              dirty = 1'b0;
  logic [NP-1:0]     data_avail = '0;
  logic [1:0]        first_resp = '0;
  logic [NP*DW-1:0]  cd_data = '0;
  logic [NP-1:0]     cd_last = '0;
  logic [NP-1:0]     cd_valid = '0;
  logic [NP-1:0]     cd_ready;
  logic [DW-1:0]     r_data;
  logic [IW-1:0]     r_id;
  logic [3:0]        r_resp;
  logic              r_last;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic              busy;
  logic [31:0]       perf_beats;
  logic [31:0]       perf_stall;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int txn_cnt   = 0;
  int unsigned exp_beats  = 0;
  int unsigned exp_stalls = 0;

  always #5 clk = ~clk;

  ccu_snoop_data_forwarder #(
    .LineWords (LW),
    .DataWidth (DW),
    .NoMstPorts(NP),
    .IdWidth   (IW),
    .FifoDepth (FD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_id_i    (req_id),
    .req_word_i  (req_word),
    .req_len_i   (req_len),
    .shared_i    (shared),
    .dirty_i     (dirty),
    .data_avail_i(data_avail),
    .first_resp_i(first_resp),
    .cd_data_i   (cd_data),
    .cd_last_i   (cd_last),
    .cd_valid_i  (cd_valid),
    .cd_ready_o  (cd_ready),
    .r_data_o    (r_data),
    .r_id_o      (r_id),
    .r_resp_o    (r_resp),
    .r_last_o    (r_last),
    .r_valid_o   (r_valid),
    .r_ready_i   (r_ready),
    .busy_o      (busy),
    .perf_beats_o(perf_beats),
    .perf_stall_o(perf_stall)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Perf model: every sampled cycle with R valid is either a beat or a stall.
  task automatic track_perf();
    if (r_valid && r_ready)  exp_beats++;
    if (r_valid && !r_ready) exp_stalls++;
  endtask

  task automatic run_inv_ack(input logic [IW-1:0] id, input int low_cycles);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_id    = id;
    r_ready   = (low_cycles == 0);
    #1;
    check_value("ack_valid", r_valid, 1);
    check_value("ack_id", r_id, id);
    check_value("ack_last", r_last, 1);
    check_value("ack_resp", r_resp, 0);
    check_value("ack_data", r_data, 0);
    track_perf();
    for (int c = 1; c <= low_cycles; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_id    = IW'($urandom);
      r_ready   = (c == low_cycles);
      #1;
      check_value("ack_hold_valid", r_valid, 1);
      check_value("ack_hold_id", r_id, id);
      check_value("ack_hold_last", r_last, 1);
      check_value("ack_hold_resp", r_resp, 0);
      track_perf();
    end
    @(negedge clk);
    req_valid = 1'b0;
    r_ready   = 1'b0;
    #1;
    check_value("ack_after_valid", r_valid, 0);
    check_value("ack_after_busy", busy, 0);
    check_value("ack_after_req_ready", req_ready, 1);
    txn_cnt++;
    $display("txn %0d inv_ack id=%0d low=%0d", txn_cnt, id, low_cycles);
  endtask

  task automatic run_nop(input logic [1:0] op);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_id    = IW'($urandom);
    r_ready   = 1'b1;
    #1;
    check_value("nop_valid", r_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    r_ready   = 1'b0;
    #1;
    check_value("nop_busy", busy, 0);
    check_value("nop_req_ready", req_ready, 1);
    txn_cnt++;
    $display("txn %0d nop op=%0d", txn_cnt, op);
  endtask

  task automatic run_forward(input int start, input int len, input logic [NP-1:0] avail,
                             input int first, input bit sh, input bit dt,
                             input int hold, input int abort_after);
    logic [DW-1:0] line [NP][LW];
    int            sent [NP];
    bit            vr   [NP];
    beat_t         exp_q[$];
    beat_t         b;
    logic [NP-1:0] eff;
    logic [IW-1:0] id;
    logic [3:0]    resp_e;
    logic [DW-1:0] p_data;
    logic [IW-1:0] p_id;
    logic [3:0]    p_resp;
    logic          p_last;
    int            endw, cyc, viol, absorbed;
    bit            oob, done, pend;

    id = IW'($urandom);
    for (int p = 0; p < NP; p++) begin
      sent[p] = 0;
      vr[p]   = 1'b0;
      for (int w = 0; w < LW; w++) line[p][w] = {$urandom, $urandom};
    end
    eff = avail;
    eff[first] = 1'b1;
    oob    = (start + len > LW - 1);
    endw   = oob ? LW - 1 : start + len;
    resp_e = {sh, dt, (oob ? 2'b10 : 2'b00)};
    for (int w = start; w <= endw; w++) begin
      b.data = line[first][w];
      b.last = (w == endw);
      exp_q.push_back(b);
    end
    absorbed = (start + FD > LW) ? LW : start + FD;

    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = 2'd2;
    req_id     = id;
    req_word   = 2'(start);
    req_len    = 8'(len);
    shared     = sh;
    dirty      = dt;
    data_avail = avail;
    first_resp = 2'(first);
    r_ready    = 1'b0;
    #1;
    check_value("fwd_req_ready", req_ready, 1);

    done = 1'b0;
    pend = 1'b0;
    viol = 0;
    cyc  = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      req_valid = 1'b0;
      r_ready   = (hold > 0 && cyc <= hold) ? 1'b0 : ($urandom % 4 != 0);
      for (int p = 0; p < NP; p++) begin
        if (!vr[p] && sent[p] < LW)
          vr[p] = (hold > 0 && cyc <= hold) ? 1'b1 : ($urandom % 4 != 0);
        cd_valid[p]           = vr[p];
        cd_data[p*DW +: DW]   = vr[p] ? line[p][sent[p]] : '0;
        cd_last[p]            = vr[p] && (sent[p] == LW - 1);
      end
      #1;
      track_perf();
      if (cyc == 0) check_value("fwd_busy", busy, 1);
      if (hold > 0 && cyc == hold) begin
        check_value("hold_absorbed", sent[first], absorbed);
        check_value("hold_cd_ready", cd_ready[first], 0);
      end
      if (pend) begin
        check_value("r_stable_valid", r_valid, 1);
        check_value("r_stable_data", r_data, p_data);
        check_value("r_stable_id", r_id, p_id);
        check_value("r_stable_resp", r_resp, p_resp);
        check_value("r_stable_last", r_last, p_last);
      end
      if (cyc > 0 && !busy) done = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (cd_ready[p] && !eff[p]) viol++;
        if (vr[p] && cd_ready[p]) begin
          sent[p]++;
          vr[p] = 1'b0;
        end
      end
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          check_value("r_extra_beat", r_valid, 0);
        end else begin
          b = exp_q.pop_front();
          check_value("r_data", r_data, b.data);
          check_value("r_last", r_last, b.last);
          check_value("r_resp", r_resp, resp_e);
          check_value("r_id", r_id, id);
        end
      end
      pend   = r_valid && !r_ready;
      p_data = r_data;
      p_id   = r_id;
      p_resp = r_resp;
      p_last = r_last;
      cyc++;
      if (abort_after > 0 && cyc >= abort_after) begin
        txn_cnt++;
        $display("txn %0d forward aborted after %0d cycles", txn_cnt, cyc);
        return;
      end
    end

    cd_valid = '0;
    cd_last  = '0;
    r_ready  = 1'b0;
    check_value("fwd_done", done, 1);
    check_value("fwd_beats_left", exp_q.size(), 0);
    for (int p = 0; p < NP; p++) check_value("cd_drained", sent[p], eff[p] ? LW : 0);
    check_value("cd_ready_nonavail", viol, 0);
    check_value("fwd_idle_req_ready", req_ready, 1);
    txn_cnt++;
    $display("txn %0d forward start=%0d len=%0d avail=%b first=%0d resp=%b beats=%0d cycles=%0d",
             txn_cnt, start, len, avail, first, resp_e, endw - start + 1, cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total_cnt, bad_cnt);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_value("rst_r_valid", r_valid, 0);
    check_value("rst_cd_ready", cd_ready, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_req_ready", req_ready, 1);
    check_value("rst_perf_beats", perf_beats, 0);
    check_value("rst_perf_stall", perf_stall, 0);
    rst = 1'b0;

    run_inv_ack(6'd5, 0);
    run_inv_ack(6'd7, 3);
    run_forward(0, 3, 4'b0011, 0, 1'b1, 1'b0, 0, 0);
    run_forward(2, 0, 4'b0101, 2, 1'b0, 1'b0, 8, 0);
    run_forward(0, 3, 4'b1001, 3, 1'b0, 1'b1, 8, 0);
    run_forward(3, 2, 4'b1111, 1, 1'b0, 1'b1, 0, 0);

    // Reset in the middle of a burst, then a clean burst afterwards.
    run_forward(0, 3, 4'b1111, 1, 1'b1, 1'b1, 0, 4);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    cd_valid  = '0;
    cd_last   = '0;
    r_ready   = 1'b0;
    exp_beats  = 0;
    exp_stalls = 0;
    @(negedge clk);
    #1;
    check_value("midrst_r_valid", r_valid, 0);
    check_value("midrst_cd_ready", cd_ready, 0);
    check_value("midrst_busy", busy, 0);
    check_value("midrst_req_ready", req_ready, 1);
    check_value("midrst_perf_beats", perf_beats, 0);
    check_value("midrst_perf_stall", perf_stall, 0);
    rst = 1'b0;
    run_forward(1, 2, 4'b0110, 2, 1'b1, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = $urandom % 10;
      if (sel == 0) begin
        run_inv_ack(IW'($urandom), $urandom % 4);
      end else if (sel == 1) begin
        run_nop(($urandom % 2 == 0) ? 2'd0 : 2'd3);
      end else begin
        run_forward($urandom % LW,
                    ($urandom % 5 == 0) ? $urandom % 256 : $urandom % LW,
                    NP'($urandom),
                    $urandom % NP,
                    1'($urandom), 1'($urandom),
                    ($urandom % 4 == 0) ? 8 : 0,
                    0);
      end
    end

    @(negedge clk);
    #1;
`ifdef CCU_SNOOP_FWD_PERF_EN
    check_value("perf_beats", perf_beats, exp_beats);
    check_value("perf_stall", perf_stall, exp_stalls);
`else
    check_value("perf_beats", perf_beats, 0);
    check_value("perf_stall", perf_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_data_forwarder.md
Name: ccu_snoop_data_forwarder

Overview:
- Next-generation snoop data unit in the CCU controller; takes over the snoop-unit role.
- Takes a decoded read request plus snoop results and streams the first responder's CD line data out as AXI R beats.
- Drains the CD channel of every port holding data.
- Generalised to any line length (LineWords), any sub-line start word and burst length, a configurable skid FIFO, and SLVERR reporting for out-of-line bursts.

Parameters:
LineWords, 4, data words per cache line; power of two, >=2
DataWidth, 64, AXI/CD data width in bits
NoMstPorts, 4, number of snooped ports; >=2
IdWidth, 6, AXI ID width
FifoDepth, 2, CD-to-R buffer depth in words; >=1
(derived) WIdxW = $clog2(LineWords); PortW = $clog2(NoMstPorts)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted, only in IDLE
- req_op_i  in  2  0=NOP, 1=INVALID_ACK, 2=FORWARD, 3=reserved (treated as NOP)
- req_id_i  in  IdWidth  AXI AR id
- req_word_i  in  WIdxW  start word index within line (AR addr word bits)
- req_len_i  in  8  AR len (beats-1)
- shared_i  in  1  line shared elsewhere
- dirty_i  in  1  any copy dirty
- data_avail_i  in  NoMstPorts  ports that will return CD data
- first_resp_i  in  PortW  port whose data is forwarded
- cd_data_i  in  NoMstPorts*DataWidth  CD data, port i at slice i
- cd_last_i  in  NoMstPorts  CD last
- cd_valid_i  in  NoMstPorts  CD valid
- cd_ready_o  out  NoMstPorts  CD ready
- r_data_o  out  DataWidth  R data
- r_id_o  out  IdWidth  R id
- r_resp_o  out  4  R resp: [3]=IsShared, [2]=PassDirty, [1:0]=OKAY/SLVERR
- r_last_o  out  1  R last
- r_valid_o  out  1  R valid
- r_ready_i  in  1  R ready
- busy_o  out  1  CD channel owned by this block
- perf_beats_o  out  32  forwarded-beat counter (optional feature)
- perf_stall_o  out  32  R-stall counter (optional feature)

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high (rst_i, sampled on rising clk_i). Reset mid-operation abandons any burst and flushes the FIFO.
- Reset values: state=IDLE, all captured registers 0, FIFO empty. Outputs: r_valid_o=0, cd_ready_o=0, busy_o=0, req_ready_o=1, perf counters 0.
- Request capture: on req_valid_i&&req_ready_o with FORWARD, register id, word, len, shared, dirty, data_avail, first_resp; go to STREAM.
- States: IDLE, ACK, STREAM, DRAIN.
- IDLE, INVALID_ACK: drive r_valid_o=1 combinationally in the same cycle with r_id_o=req_id_i, r_last_o=1, r_data_o=0, r_resp_o=0.
  - r_ready_i=1: stay in IDLE.
  - r_ready_i=0: latch the id and go to ACK, which holds the beat until r_ready_i, then returns to IDLE.
- NOP: accepted, no effect.
- STREAM, receive side:
  - Counter rx_word (WIdxW+1 bits) counts first-responder CD beats pushed to the FIFO.
  - Words with index < start or index > end are popped without R output (discard pops need no r_ready_i).
  - end = start+len.
- STREAM, send side:
  - Each FIFO word inside [start,end] is presented on R with id, resp[3]=shared, resp[2]=dirty.
  - r_last_o=1 on word end.
  - Pop on r_valid_o&&r_ready_i.
- Out-of-line burst: if start+len > LineWords-1, end clamps to LineWords-1 and resp[1:0]=2'b10 (SLVERR) on every beat.
- R rule: R payload is stable while r_valid_o && !r_ready_i.
- Leaving STREAM: after the last R beat, go to IDLE if every port in data_avail has seen cd_last, else to DRAIN. DRAIN goes to IDLE when that condition holds.
- busy_o = state in {STREAM, DRAIN}.
- cd_ready_o[i] = busy_o && data_avail[i] && !last_seen[i].
  - The first responder is additionally gated by !fifo_full.
  - last_seen[i] is set on cd_valid_i[i]&&cd_ready_o[i]&&cd_last_i[i] and cleared when !busy_o.
- FIFO: push on first-responder CD handshake in STREAM. Flushed when !busy_o. Simultaneous push and pop when full is not allowed (ready is gated). Push and pop in the same cycle when partially full is allowed.
- Throughput: 1 beat/cycle sustained when FifoDepth>=2. Latency from CD handshake to R valid is 1 cycle.
- Error cases:
  - First responder not in data_avail: treated as a data_avail bit. It is never cleared.
  - CD last arriving before LineWords words: the burst terminates with r_last on the last received word, resp=SLVERR.

Optional Feature:
- Macro: CCU_SNOOP_FWD_PERF_EN.
- Defined:
  - perf_beats_o increments per R handshake, including ACK beats.
  - perf_stall_o increments each cycle r_valid_o&&!r_ready_i.
  - Both saturate at 2^32-1 and are cleared only by rst_i.
- Undefined: both outputs tied to 0 and no counter flops are instantiated.

Test Plan:
- INVALID_ACK, id=5, r_ready_i=1 -> same-cycle R beat id=5, last=1, resp=0; then IDLE with busy_o=0.
- INVALID_ACK, id=7, r_ready_i low for 3 cycles -> R beat id=7 held stable for 4 cycles; one handshake, then IDLE.
- FORWARD, LineWords=4, start=0, len=3, data_avail=4'b0011, first=0, shared=1, dirty=0; port 0 sends words A..D, port 1 sends 4 words -> R beats A,B,C,D, last on D, resp=4'b1000; both CD channels drained; IDLE.
- FORWARD, start=2, len=0 -> words 0,1,3 discarded, single R beat = word 2 with last=1; with r_ready_i held low, cd_ready_o[first] drops once FIFO holds FifoDepth words.
- FORWARD, start=3, len=2 -> one beat (word 3), last=1, resp[1:0]=2'b10.
- rst_i asserted mid-STREAM -> next cycle r_valid_o=0, cd_ready_o=0, busy_o=0, FIFO empty; new FORWARD then completes normally; with CCU_SNOOP_FWD_PERF_EN, counters read 0 after reset.
